// File: rtl/sd_pkg.sv
// sd_pkg: shared SD init constants, command table values, state and error encodings.
package sd_pkg;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RELEASE, S_CHECK, S_READY, S_ERROR} state_t;

    typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD17} cmd_t;

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_CMD0    = 3'd1,
        E_CMD8    = 3'd2,
        E_ACMD41  = 3'd3,
        E_TIMEOUT = 3'd4,
        E_CMD17   = 3'd5
    } err_t;

    localparam logic [7:0]  CMD0_NUM   = 8'h40;
    localparam logic [31:0] CMD0_ARG   = 32'h0000_0000;
    localparam logic [7:0]  CMD0_CRC   = 8'h95;
    localparam logic [7:0]  CMD8_NUM   = 8'h48;
    localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
    localparam logic [7:0]  CMD8_CRC   = 8'h87;
    localparam logic [7:0]  CMD55_NUM  = 8'h77;
    localparam logic [31:0] CMD55_ARG  = 32'h0000_0000;
    localparam logic [7:0]  CMD55_CRC  = 8'h65;
    localparam logic [7:0]  ACMD41_NUM = 8'h69;
    localparam logic [31:0] ACMD41_ARG = 32'h4000_0000;
    localparam logic [7:0]  ACMD41_CRC = 8'h77;
    localparam logic [7:0]  CMD17_NUM  = 8'h51;
    localparam logic [7:0]  CMD17_CRC  = 8'hFF;

    localparam logic [7:0]  R1_OK      = 8'h00;
    localparam logic [7:0]  R1_IDLE    = 8'h01;

endpackage

// File: rtl/sd_init_seq.sv
// sd_init_seq: drives an SD command engine through CMD0/CMD8/CMD55/ACMD41 init
// and single-block CMD17 reads, one command outstanding at a time.
module sd_init_seq
    import sd_pkg::*;
#(
    parameter int CMD_TIMEOUT    = 65535,
    parameter int ACMD41_RETRIES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        read_req,
    input  logic [31:0] read_addr,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  resp_flags,
    output logic        ready,
    output logic        read_done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [7:0]  last_r1
);

    localparam int WD_W = (CMD_TIMEOUT < 2) ? 1 : $clog2(CMD_TIMEOUT + 1);
    localparam int RT_W = (ACMD41_RETRIES < 1) ? 1 : $clog2(ACMD41_RETRIES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(CMD_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(ACMD41_RETRIES);

    state_t          state, state_n;
    cmd_t            cmd, cmd_n;
    err_t            err, err_n;
    logic [31:0]     addr, addr_n;
    logic [WD_W-1:0] wdog, wdog_n;
    logic [RT_W-1:0] retry, retry_n;
    logic [7:0]      r1_n;
    logic            go_q, go_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cmd     <= C_CMD0;
            err     <= E_NONE;
            addr    <= '0;
            wdog    <= '0;
            retry   <= '0;
            last_r1 <= '0;
            go_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cmd     <= cmd_n;
            err     <= err_n;
            addr    <= addr_n;
            wdog    <= wdog_n;
            retry   <= retry_n;
            last_r1 <= r1_n;
            go_q    <= go;
        end
    end

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        err_n   = err;
        addr_n  = addr;
        wdog_n  = '0;
        retry_n = retry;
        r1_n    = last_r1;
        go_rise = go & ~go_q;
        case (state)
            S_IDLE, S_ERROR: begin
                if (go_rise) begin
                    state_n = S_ISSUE;
                    cmd_n   = C_CMD0;
                    err_n   = E_NONE;
                    retry_n = '0;
                end
            end
            S_ISSUE: begin
                if (cmd_done) begin
                    state_n = S_RELEASE;
                    r1_n    = resp_flags;
                end else if (wdog == WD_LAST) begin
                    state_n = S_ERROR;
                    err_n   = E_TIMEOUT;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            S_RELEASE: state_n = cmd_done ? S_RELEASE : S_CHECK;
            S_CHECK: begin
                state_n = S_ERROR;
                case (cmd)
                    C_CMD0: begin
                        if (last_r1 == R1_IDLE) begin
                            state_n = S_ISSUE;
                            cmd_n   = C_CMD8;
                        end else err_n = E_CMD0;
                    end
                    C_CMD8: begin
                        if (last_r1 == R1_IDLE) begin
                            state_n = S_ISSUE;
                            cmd_n   = C_CMD55;
                        end else err_n = E_CMD8;
                    end
                    C_CMD55: begin
                        if (last_r1 == R1_OK || last_r1 == R1_IDLE) begin
                            state_n = S_ISSUE;
                            cmd_n   = C_ACMD41;
                        end else err_n = E_ACMD41;
                    end
                    C_ACMD41: begin
                        if (last_r1 == R1_OK) begin
                            state_n = S_READY;
                        end else if (last_r1 == R1_IDLE && retry < RT_MAX) begin
                            state_n = S_ISSUE;
                            cmd_n   = C_CMD55;
                            retry_n = retry + 1'b1;
                        end else err_n = E_ACMD41;
                    end
                    default: begin
                        if (last_r1 == R1_OK) state_n = S_READY;
                        else err_n = E_CMD17;
                    end
                endcase
            end
            S_READY: begin
                if (read_req) begin
                    state_n = S_ISSUE;
                    cmd_n   = C_CMD17;
                    addr_n  = read_addr;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Command table decoded from the held command, so cmd_* stays stable through ISSUE.
    always_comb begin
        cmd_number = CMD0_NUM;
        cmd_args   = CMD0_ARG;
        cmd_crc    = CMD0_CRC;
        case (cmd)
            C_CMD8: begin
                cmd_number = CMD8_NUM;
                cmd_args   = CMD8_ARG;
                cmd_crc    = CMD8_CRC;
            end
            C_CMD55: begin
                cmd_number = CMD55_NUM;
                cmd_args   = CMD55_ARG;
                cmd_crc    = CMD55_CRC;
            end
            C_ACMD41: begin
                cmd_number = ACMD41_NUM;
                cmd_args   = ACMD41_ARG;
                cmd_crc    = ACMD41_CRC;
            end
            C_CMD17: begin
                cmd_number = CMD17_NUM;
                cmd_args   = addr;
                cmd_crc    = CMD17_CRC;
            end
            default: ;
        endcase
    end

    assign cmd_start = state == S_ISSUE;
    assign ready     = state == S_READY;
    assign error     = state == S_ERROR;
    assign read_done = state == S_CHECK && cmd == C_CMD17 && last_r1 == R1_OK;
    assign err_code  = err;

endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: command-engine model plus scoreboard of expected commands for sd_init_seq.
module tb_sd_init_seq;
    import sd_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        logic [7:0]  num;
        logic [31:0] args;
        logic [7:0]  crc;
    } cmd_rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        read_req = 1'b0;
    logic [31:0] read_addr = '0;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic        cmd_start;
    logic        cmd_done;
    logic [7:0]  resp_flags;
    logic        ready, read_done, error;
    logic [2:0]  err_code;
    logic [7:0]  last_r1;

    cmd_rec_t   exp_q[$];
    logic [7:0] r1_q[$];
    cmd_rec_t   exp_cmd;
    int tests = 0;
    int fails = 0;
    bit eng_en = 1'b1;
    bit busy = 1'b0;
    int cnt = 0;
    int n_acmd41 = 0;
    int n_rd = 0;

    always #5 clk = ~clk;

    sd_init_seq #(.CMD_TIMEOUT(16), .ACMD41_RETRIES(3)) dut (
        .clk(clk), .reset(reset), .go(go), .read_req(read_req), .read_addr(read_addr),
        .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc), .cmd_start(cmd_start),
        .cmd_done(cmd_done), .resp_flags(resp_flags), .ready(ready), .read_done(read_done),
        .error(error), .err_code(err_code), .last_r1(last_r1)
    );

    // Command engine: done N cycles after start, drops one cycle after start falls.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_done   <= 1'b0;
            resp_flags <= 8'h00;
            busy = 1'b0;
            cnt  = 0;
        end else begin
            if (cmd_start && !busy) begin
                busy = 1'b1;
                cnt  = 0;
                if (cmd_number == ACMD41_NUM) n_acmd41++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL cmd_issue: got unexpected cmd %h/%h/%h", cmd_number, cmd_args, cmd_crc);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    if ({cmd_number, cmd_args, cmd_crc} !== exp_cmd) begin
                        fails++;
                        $display("FAIL cmd_issue: got %h/%h/%h expected %h/%h/%h", cmd_number, cmd_args,
                                 cmd_crc, exp_cmd.num, exp_cmd.args, exp_cmd.crc);
                    end
                end
                tests++;
                if (cmd_done !== 1'b0) begin
                    fails++;
                    $display("FAIL start_while_done: cmd_done=%b expected 0", cmd_done);
                end
            end
            if (cmd_start && busy && !cmd_done && eng_en) begin
                cnt++;
                if (cnt >= N) begin
                    cmd_done   <= 1'b1;
                    resp_flags <= (r1_q.size() != 0) ? r1_q.pop_front() : 8'hFF;
                end
            end
            if (!cmd_start && busy) begin
                cmd_done <= 1'b0;
                busy = 1'b0;
            end
        end
    end

    always @(posedge clk) if (read_done) n_rd++;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_cmd(input logic [7:0] n, input logic [31:0] a, input logic [7:0] c, input logic [7:0] r1);
        exp_q.push_back({n, a, c});
        r1_q.push_back(r1);
    endtask

    task automatic pulse_go;
        go = 1'b1;
        cyc(2);
        go = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        exp_q.delete();
        r1_q.delete();
        eng_en = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic wait_settle(input string name, input int budget);
        int i = 0;
        while (!ready && !error && i < budget) begin
            cyc(1);
            i++;
        end
        tests++;
        if (!ready && !error) begin
            fails++;
            $display("FAIL %s: no ready/error within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if ({cmd_start, ready, read_done, error} !== 4'b0) begin
            fails++;
            $display("FAIL %s_flags: start/ready/rd/err=%b expected 0000", name, {cmd_start, ready, read_done, error});
        end
        tests++;
        if ({cmd_number, cmd_args, cmd_crc} !== {CMD0_NUM, CMD0_ARG, CMD0_CRC}) begin
            fails++;
            $display("FAIL %s_cmd: got %h/%h/%h expected 40/00000000/95", name, cmd_number, cmd_args, cmd_crc);
        end
        tests++;
        if ({err_code, last_r1} !== 11'd0) begin
            fails++;
            $display("FAIL %s_regs: err_code=%0d last_r1=%h expected 0/00", name, err_code, last_r1);
        end
    endtask

    task automatic test_reset;
        cyc(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic test_read_dropped;
        read_req  = 1'b1;
        read_addr = 32'hDEAD_BEEF;
        cyc(1);
        read_req = 1'b0;
        cyc(5);
        tests++;
        if ({cmd_start, ready} !== 2'b00) begin
            fails++;
            $display("FAIL read_dropped: start/ready=%b expected 00", {cmd_start, ready});
        end
    endtask

    task automatic test_happy;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h01);
        expect_cmd(CMD8_NUM, CMD8_ARG, CMD8_CRC, 8'h01);
        expect_cmd(CMD55_NUM, CMD55_ARG, CMD55_CRC, 8'h01);
        expect_cmd(ACMD41_NUM, ACMD41_ARG, ACMD41_CRC, 8'h00);
        pulse_go;
        wait_settle("happy", 500);
        tests++;
        if ({ready, error, err_code, last_r1} !== {2'b10, 3'd0, 8'h00}) begin
            fails++;
            $display("FAIL happy_done: ready=%b error=%b err_code=%0d last_r1=%h expected 1/0/0/00",
                     ready, error, err_code, last_r1);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL happy_order: %0d commands not issued, expected 0", exp_q.size());
        end
    endtask

    task automatic test_read;
        int rd0 = n_rd;
        expect_cmd(CMD17_NUM, 32'h0000_1234, CMD17_CRC, 8'h00);
        read_addr = 32'h0000_1234;
        read_req  = 1'b1;
        cyc(1);
        read_req  = 1'b0;
        read_addr = 32'h0;
        wait_settle("read", 200);
        tests++;
        if ({ready, error} !== 2'b10) begin
            fails++;
            $display("FAIL read_ready: ready/error=%b expected 10", {ready, error});
        end
        tests++;
        if (n_rd - rd0 != 1) begin
            fails++;
            $display("FAIL read_done_count: got %0d pulses expected 1", n_rd - rd0);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL read_issue: %0d commands not issued, expected 0", exp_q.size());
        end
    endtask

    task automatic test_acmd41_retry;
        int a0;
        do_reset;
        a0 = n_acmd41;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h01);
        expect_cmd(CMD8_NUM, CMD8_ARG, CMD8_CRC, 8'h01);
        for (int i = 0; i < 4; i++) begin
            expect_cmd(CMD55_NUM, CMD55_ARG, CMD55_CRC, 8'h01);
            expect_cmd(ACMD41_NUM, ACMD41_ARG, ACMD41_CRC, (i < 3) ? 8'h01 : 8'h00);
        end
        pulse_go;
        wait_settle("retry", 1000);
        tests++;
        if ({ready, err_code} !== {1'b1, 3'd0}) begin
            fails++;
            $display("FAIL retry_ready: ready=%b err_code=%0d expected 1/0", ready, err_code);
        end
        tests++;
        if (n_acmd41 - a0 != 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL retry_pairs: got %0d ACMD41 (%0d left) expected 4 (0 left)", n_acmd41 - a0, exp_q.size());
        end
    endtask

    task automatic test_retry_exhausted;
        do_reset;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h01);
        expect_cmd(CMD8_NUM, CMD8_ARG, CMD8_CRC, 8'h01);
        for (int i = 0; i < 4; i++) begin
            expect_cmd(CMD55_NUM, CMD55_ARG, CMD55_CRC, 8'h01);
            expect_cmd(ACMD41_NUM, ACMD41_ARG, ACMD41_CRC, 8'h01);
        end
        pulse_go;
        wait_settle("exhaust", 1000);
        tests++;
        if ({error, err_code, last_r1} !== {1'b1, 3'd3, 8'h01}) begin
            fails++;
            $display("FAIL exhaust_err: error=%b err_code=%0d last_r1=%h expected 1/3/01", error, err_code, last_r1);
        end
    endtask

    task automatic test_timeout;
        int n = 0;
        do_reset;
        eng_en = 1'b0;
        exp_q.push_back({CMD0_NUM, CMD0_ARG, CMD0_CRC});
        go = 1'b1;
        cyc(1);
        while (cmd_start && n < 100) begin
            n++;
            cyc(1);
        end
        go = 1'b0;
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d ISSUE cycles expected 16", n);
        end
        tests++;
        if ({error, err_code, cmd_start} !== {1'b1, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL timeout_err: error=%b err_code=%0d cmd_start=%b expected 1/4/0", error, err_code, cmd_start);
        end
        cyc(1);
        eng_en = 1'b1;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h01);
        expect_cmd(CMD8_NUM, CMD8_ARG, CMD8_CRC, 8'h01);
        expect_cmd(CMD55_NUM, CMD55_ARG, CMD55_CRC, 8'h00);
        expect_cmd(ACMD41_NUM, ACMD41_ARG, ACMD41_CRC, 8'h00);
        pulse_go;
        tests++;
        if (err_code !== 3'd0) begin
            fails++;
            $display("FAIL timeout_clear: err_code=%0d expected 0", err_code);
        end
        wait_settle("timeout_restart", 500);
        tests++;
        if (ready !== 1'b1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_restart: ready=%b left=%0d expected 1/0", ready, exp_q.size());
        end
    endtask

    task automatic test_bad_cmd0;
        do_reset;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h05);
        go = 1'b1;
        cyc(1);
        wait_settle("bad_cmd0", 200);
        tests++;
        if ({error, err_code, last_r1} !== {1'b1, 3'd1, 8'h05}) begin
            fails++;
            $display("FAIL bad_cmd0: error=%b err_code=%0d last_r1=%h expected 1/1/05", error, err_code, last_r1);
        end
        cyc(8);
        tests++;
        if ({error, cmd_start} !== 2'b10 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL go_held: error/start=%b extra=%0d expected 10/0", {error, cmd_start}, exp_q.size());
        end
        go = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_cmd;
        int i = 0;
        int rd0;
        expect_cmd(CMD0_NUM, CMD0_ARG, CMD0_CRC, 8'h01);
        expect_cmd(CMD8_NUM, CMD8_ARG, CMD8_CRC, 8'h01);
        pulse_go;
        while (!(cmd_start && cmd_number == CMD8_NUM) && i < 200) begin
            cyc(1);
            i++;
        end
        tests++;
        if (!(cmd_start && cmd_number == CMD8_NUM)) begin
            fails++;
            $display("FAIL mid_reach: cmd_start=%b cmd=%h expected 1/48", cmd_start, cmd_number);
        end
        rd0 = n_rd;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        r1_q.delete();
        cyc(2);
        reset = 1'b1;
        cyc(4);
        tests++;
        if (n_rd != rd0 || cmd_start !== 1'b0) begin
            fails++;
            $display("FAIL mid_after: read_done pulses=%0d cmd_start=%b expected 0/0", n_rd - rd0, cmd_start);
        end
    endtask

    initial begin
        test_reset;
        test_read_dropped;
        test_happy;
        test_read;
        test_acmd41_retry;
        test_retry_exhausted;
        test_timeout;
        test_bad_cmd0;
        test_reset_mid_cmd;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
